// File: rtl/pll_reset_sequencer_if.sv
// Control and status bundle for the PLL reset sequencer.
// slave: the sequencer itself. master: whatever drives the lock/requests and reads status.
interface pll_reset_sequencer_if;

    logic       pll_locked;
    logic       sw_reset_req;
    logic       clear_status;
    logic       core_rst_n;
    logic       periph_rst_n;
    logic       ready;
    logic [1:0] state;
    logic [7:0] lock_loss_count;
    logic       lock_lost_sticky;

    modport master (
        output pll_locked,
        output sw_reset_req,
        output clear_status,
        input  core_rst_n,
        input  periph_rst_n,
        input  ready,
        input  state,
        input  lock_loss_count,
        input  lock_lost_sticky
    );

    modport slave (
        input  pll_locked,
        input  sw_reset_req,
        input  clear_status,
        output core_rst_n,
        output periph_rst_n,
        output ready,
        output state,
        output lock_loss_count,
        output lock_lost_sticky
    );

endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: waits for a stable synchronised lock, releases core
// reset, then peripheral reset after a gap. A filtered lock loss or a software
// request re-asserts both resets and restarts the sequence. Keeps a saturating
// lock-loss counter and a sticky loss flag.
module pll_reset_sequencer #(
    parameter int unsigned STABLE_CYCLES = 4096,
    parameter int unsigned STAGE_GAP     = 16,
    parameter int unsigned GLITCH_CYCLES = 4
) (
    input  logic                  clock,
    input  logic                  resetn,
    pll_reset_sequencer_if.slave  sq_if
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned LOW_W  = 8;
    localparam int unsigned STAT_W = 8;

    localparam logic [CNT_W-1:0]  STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST    = CNT_W'(STAGE_GAP - 1);
    localparam logic [LOW_W-1:0]  GLITCH_N    = LOW_W'(GLITCH_CYCLES);
    localparam logic [STAT_W-1:0] STAT_MAX    = {STAT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_STABILIZE = 2'd1,
        ST_RELEASE   = 2'd2,
        ST_RUN       = 2'd3
    } state_e;

    state_e              state_q,  state_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic [LOW_W-1:0]    lowcnt_q, lowcnt_d;
    logic [STAT_W-1:0]   loss_count_q, loss_count_d;
    logic                sticky_q, sticky_d;
    logic                sync1_q, sync2_q;
    logic                core_rst_n_q, periph_rst_n_q, ready_q;

    logic                locked_s;
    logic                filter_on_c;
    logic                loss_event_c;
    logic [LOW_W-1:0]    lowcnt_inc_c;

    assign locked_s = sync2_q;

    // Two-flop synchroniser for the asynchronous PLL lock input.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sq_if.pll_locked;
            sync2_q <= sync1_q;
        end
    end

    // Loss filter: only armed once core reset is released; an event is a full
    // run of GLITCH_CYCLES unlocked samples already accumulated in lowcnt_q.
    always_comb begin
        filter_on_c  = (state_q == ST_RELEASE) || (state_q == ST_RUN);
        loss_event_c = filter_on_c && (lowcnt_q >= GLITCH_N);
        if (locked_s) begin
            lowcnt_inc_c = '0;
        end else if (lowcnt_q == {LOW_W{1'b1}}) begin
            lowcnt_inc_c = lowcnt_q;
        end else begin
            lowcnt_inc_c = lowcnt_q + LOW_W'(1);
        end
    end

    // Next-state logic; priority is sw_reset_req > loss event > normal flow.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lowcnt_d = '0;

        case (state_q)
            ST_WAIT_LOCK: begin
                cnt_d = '0;
                if (locked_s) begin
                    state_d = ST_STABILIZE;
                end
            end
            ST_STABILIZE: begin
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                lowcnt_d = lowcnt_inc_c;
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                lowcnt_d = lowcnt_inc_c;
                cnt_d    = '0;
            end
            default: begin
                state_d = ST_WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase

        // The glitch count never carries across a state boundary.
        if (state_d != state_q) begin
            lowcnt_d = '0;
        end

        if (loss_event_c || sq_if.sw_reset_req) begin
            state_d  = ST_WAIT_LOCK;
            cnt_d    = '0;
            lowcnt_d = '0;
        end
    end

    // Status next-state: a loss event beats a simultaneous clear, restarting at 1.
    always_comb begin
        loss_count_d = loss_count_q;
        sticky_d     = sticky_q;
        if (loss_event_c) begin
            sticky_d = 1'b1;
            if (sq_if.clear_status) begin
                loss_count_d = STAT_W'(1);
            end else if (loss_count_q == STAT_MAX) begin
                loss_count_d = STAT_MAX;
            end else begin
                loss_count_d = loss_count_q + STAT_W'(1);
            end
        end else if (sq_if.clear_status) begin
            loss_count_d = '0;
            sticky_d     = 1'b0;
        end
    end

    // FSM, counters and registered outputs decoded from the upcoming state.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q        <= ST_WAIT_LOCK;
            cnt_q          <= '0;
            lowcnt_q       <= '0;
            loss_count_q   <= '0;
            sticky_q       <= 1'b0;
            core_rst_n_q   <= 1'b0;
            periph_rst_n_q <= 1'b0;
            ready_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            lowcnt_q       <= lowcnt_d;
            loss_count_q   <= loss_count_d;
            sticky_q       <= sticky_d;
            core_rst_n_q   <= (state_d == ST_RELEASE) || (state_d == ST_RUN);
            periph_rst_n_q <= (state_d == ST_RUN);
            ready_q        <= (state_d == ST_RUN);
        end
    end

    assign sq_if.core_rst_n       = core_rst_n_q;
    assign sq_if.periph_rst_n     = periph_rst_n_q;
    assign sq_if.ready            = ready_q;
    assign sq_if.state            = state_q;
    assign sq_if.lock_loss_count  = loss_count_q;
    assign sq_if.lock_lost_sticky = sticky_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with STABLE=8, GAP=4, GLITCH=3.
// Inputs change and outputs are sampled on the falling edge; edge_cnt numbers rising edges.
module tb_pll_reset_sequencer;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    int   edge_cnt = 0;
    int   n_total  = 0;
    int   n_pass   = 0;
    int   timeouts = 0;

    pll_reset_sequencer_if sq_if ();

    pll_reset_sequencer #(
        .STABLE_CYCLES (8),
        .STAGE_GAP     (4),
        .GLITCH_CYCLES (3)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .sq_if  (sq_if)
    );

    always #5 clock = ~clock;

    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_cnt);
    endtask

    // Park on the falling edge that follows rising edge number t.
    task automatic wait_edge(input int t);
        while (edge_cnt < t) @(negedge clock);
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (sq_if.state == s) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic check_outs(input string tag, input logic [1:0] st, input logic c,
                              input logic p, input logic r);
        check({tag, "_state"}, 32'(sq_if.state), 32'(st));
        check({tag, "_core"},  32'(sq_if.core_rst_n), 32'(c));
        check({tag, "_per"},   32'(sq_if.periph_rst_n), 32'(p));
        check({tag, "_rdy"},   32'(sq_if.ready), 32'(r));
    endtask

    task automatic check_stat(input string tag, input int cnt, input logic sticky);
        check({tag, "_cnt"},    32'(sq_if.lock_loss_count), 32'(cnt));
        check({tag, "_sticky"}, 32'(sq_if.lock_lost_sticky), 32'(sticky));
    endtask

    initial begin
        int k;
        bit ok;
        sq_if.pll_locked   = 1'b0;
        sq_if.sw_reset_req = 1'b0;
        sq_if.clear_status = 1'b0;

        // Reset values
        repeat (3) @(negedge clock);
        check_outs("rst", 2'd0, 1'b0, 1'b0, 1'b0);
        check_stat("rst", 0, 1'b0);
        resetn = 1'b1;
        repeat (4) @(negedge clock);
        check_outs("idle", 2'd0, 1'b0, 1'b0, 1'b0);

        // Clean lock: first sampled high at edge k
        k = edge_cnt + 1;
        sq_if.pll_locked = 1'b1;
        wait_edge(k + 1);  check("cl_sync_st", 32'(sq_if.state), 32'd0);
        wait_edge(k + 2);  check("cl_stab_st", 32'(sq_if.state), 32'd1);
        wait_edge(k + 9);  check_outs("cl_pre_core", 2'd1, 1'b0, 1'b0, 1'b0);
        wait_edge(k + 10); check_outs("cl_core", 2'd2, 1'b1, 1'b0, 1'b0);
        wait_edge(k + 13); check_outs("cl_pre_run", 2'd2, 1'b1, 1'b0, 1'b0);
        wait_edge(k + 14); check_outs("cl_run", 2'd3, 1'b1, 1'b1, 1'b1);
        check_stat("cl", 0, 1'b0);

        // Two-cycle glitch is rejected
        repeat (3) @(negedge clock);
        k = edge_cnt + 1;
        sq_if.pll_locked = 1'b0;
        wait_edge(k + 1);  sq_if.pll_locked = 1'b1;
        wait_edge(k + 8);  check_outs("gl2", 2'd3, 1'b1, 1'b1, 1'b1);
        check_stat("gl2", 0, 1'b0);

        // Three-cycle drop: resets low at drop+5, then re-sequence
        k = edge_cnt + 1;
        sq_if.pll_locked = 1'b0;
        wait_edge(k + 2);  sq_if.pll_locked = 1'b1;
        wait_edge(k + 4);  check_outs("gl3_pre", 2'd3, 1'b1, 1'b1, 1'b1);
        wait_edge(k + 5);  check_outs("gl3_loss", 2'd0, 1'b0, 1'b0, 1'b0);
        check_stat("gl3", 1, 1'b1);
        wait_edge(k + 6);  check("gl3_stab", 32'(sq_if.state), 32'd1);
        wait_edge(k + 14); check("gl3_core", 32'(sq_if.core_rst_n), 32'd1);
        wait_edge(k + 18); check_outs("gl3_run", 2'd3, 1'b1, 1'b1, 1'b1);

        // Software request with lock held: pulse sampled at edge k
        k = edge_cnt + 1;
        sq_if.sw_reset_req = 1'b1;
        wait_edge(k);      sq_if.sw_reset_req = 1'b0;
        check_outs("sw", 2'd0, 1'b0, 1'b0, 1'b0);
        check_stat("sw", 1, 1'b1);
        wait_edge(k + 1);  check("sw_stab", 32'(sq_if.state), 32'd1);
        wait_edge(k + 8);  check("sw_pre_core", 32'(sq_if.core_rst_n), 32'd0);
        wait_edge(k + 9);  check_outs("sw_core", 2'd2, 1'b1, 1'b0, 1'b0);
        wait_edge(k + 13); check("sw_run", 32'(sq_if.state), 32'd3);

        // Early drop inside the stabilisation window
        sq_if.pll_locked   = 1'b0;
        sq_if.sw_reset_req = 1'b1;
        @(negedge clock);
        sq_if.sw_reset_req = 1'b0;
        repeat (5) @(negedge clock);
        check("ed_idle", 32'(sq_if.state), 32'd0);
        k = edge_cnt + 1;
        sq_if.pll_locked = 1'b1;
        wait_edge(k + 4);  sq_if.pll_locked = 1'b0;
        wait_edge(k + 5);  sq_if.pll_locked = 1'b1;
        wait_edge(k + 6);  check("ed_stab", 32'(sq_if.state), 32'd1);
        wait_edge(k + 7);  check("ed_back", 32'(sq_if.state), 32'd0);
        wait_edge(k + 8);  check("ed_restab", 32'(sq_if.state), 32'd1);
        wait_edge(k + 15); check("ed_pre_core", 32'(sq_if.core_rst_n), 32'd0);
        wait_edge(k + 16); check("ed_core", 32'(sq_if.core_rst_n), 32'd1);
        check_stat("ed", 1, 1'b1);

        // Saturation: 260 further loss events on top of the one already counted
        for (int i = 0; i < 260; i++) begin
            wait_state(2'd3, 64, ok);
            if (!ok) timeouts++;
            sq_if.pll_locked = 1'b0;
            repeat (3) @(negedge clock);
            sq_if.pll_locked = 1'b1;
            wait_state(2'd0, 16, ok);
            if (!ok) timeouts++;
        end
        check("sat_timeouts", 32'(timeouts), 32'd0);
        check_stat("sat", 255, 1'b1);

        // Clear coinciding with a loss at count 255: event wins, count restarts at 1
        wait_state(2'd3, 64, ok);
        check("cc_wait", 32'(ok), 32'd1);
        k = edge_cnt + 1;
        sq_if.pll_locked = 1'b0;
        wait_edge(k + 2);  sq_if.pll_locked = 1'b1;
        wait_edge(k + 4);  sq_if.clear_status = 1'b1;
        check("cc_pre", 32'(sq_if.state), 32'd3);
        wait_edge(k + 5);  sq_if.clear_status = 1'b0;
        check("cc_state", 32'(sq_if.state), 32'd0);
        check_stat("cc", 1, 1'b1);

        // Plain clear in RUN
        wait_state(2'd3, 64, ok);
        check("clr_wait", 32'(ok), 32'd1);
        k = edge_cnt + 1;
        sq_if.clear_status = 1'b1;
        wait_edge(k);      sq_if.clear_status = 1'b0;
        check_stat("clr", 0, 1'b0);
        check("clr_state", 32'(sq_if.state), 32'd3);

        // One more loss, then resetn pulse during RELEASE
        sq_if.pll_locked = 1'b0;
        repeat (3) @(negedge clock);
        sq_if.pll_locked = 1'b1;
        wait_state(2'd0, 16, ok);
        check("mr_loss", 32'(ok), 32'd1);
        check_stat("mr_loss", 1, 1'b1);
        wait_state(2'd2, 32, ok);
        check("mr_release", 32'(ok), 32'd1);
        k = edge_cnt + 1;
        resetn = 1'b0;
        wait_edge(k);      resetn = 1'b1;
        check_outs("mr", 2'd0, 1'b0, 1'b0, 1'b0);
        check_stat("mr", 0, 1'b0);
        wait_edge(k + 2);  check("mr_sync", 32'(sq_if.state), 32'd0);
        wait_edge(k + 3);  check("mr_stab", 32'(sq_if.state), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
